pe_tx_queue: RTL and testbench

- Leaf-side packet source for the BFT network, sitting directly upstream of a leaf's pe_interface/interface_pe/resend ports (replaces pe_start/pe_shift at a leaf).
- Accepts (dest, payload) words from a local producer via valid/ready, queues them in a small FIFO, and drives a registered packet {valid, dest, payload} into the network.
- Holds and re-presents the packet whenever the network asserts resend.
- Captures packets delivered to the leaf on interface_pe and counts them.

---
 rtl/bft_pkg.sv | 28 ++
 rtl/pe_tx_fifo.sv | 62 ++++++
 rtl/pe_tx_queue.sv | 137 +++++++++++++
 tb/tb_pe_tx_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// Shared BFT leaf definitions: leaf-address width, packet field offsets, packet builder.
// Offsets and make_pkt describe the default 16-leaf / 27-bit-payload packet format.
package bft_pkg;

  function automatic int log_l(input int n);
    return $clog2(n);
  endfunction

  localparam int BFT_NUM_LEAVES = 16;
  localparam int BFT_PAYLOAD_SZ = 27;
  localparam int BFT_LOG_L      = $clog2(BFT_NUM_LEAVES);
  localparam int BFT_P_SZ       = 1 + BFT_LOG_L + BFT_PAYLOAD_SZ;

  localparam int VALID_BIT   = BFT_P_SZ - 1;
  localparam int DEST_LSB    = BFT_PAYLOAD_SZ;
  localparam int PAYLOAD_LSB = 0;

  function automatic logic [BFT_P_SZ-1:0] make_pkt(input logic [BFT_LOG_L-1:0] dest,
                                                   input logic [BFT_PAYLOAD_SZ-1:0] payload);
    logic [BFT_P_SZ-1:0] pkt;
    pkt                                = '0;
    pkt[VALID_BIT]                     = 1'b1;
    pkt[DEST_LSB +: BFT_LOG_L]         = dest;
    pkt[PAYLOAD_LSB +: BFT_PAYLOAD_SZ] = payload;
    return pkt;
  endfunction

endpackage

// File: rtl/pe_tx_fifo.sv
// Small synchronous FIFO; caller guarantees no push when full and no pop when empty.
// rdata is the current head, valid whenever count is non-zero.
module pe_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pe_tx_queue.sv
// Leaf packet source: FIFO-buffered TX into a resend-holding output slot, plus RX capture.
// Optional resend statistics counter built only when PE_TX_RESEND_STATS_EN is defined.
module pe_tx_queue
  import bft_pkg::*;
#(
  parameter int num_leaves = 16,
  parameter int payload_sz = 27,
  parameter int p_sz       = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16,
  localparam int LOG_L     = log_l(num_leaves)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LOG_L-1:0]         in_dest,
  input  logic [payload_sz-1:0]    in_payload,
  output logic [p_sz-1:0]          pe_interface,
  input  logic [p_sz-1:0]          interface_pe,
  input  logic                     resend,
  output logic [p_sz-2:0]          rx_data,
  output logic                     rx_valid,
  output logic [CNT_W-1:0]         rx_count,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         resend_count
);

  localparam int AW = $clog2(DEPTH);

  if (p_sz != 1 + LOG_L + payload_sz) begin : g_bad_p_sz
    $error("pe_tx_queue: p_sz must equal 1 + LOG_L + payload_sz");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("pe_tx_queue: DEPTH must be a power of 2 and >= 2");
  end

  logic              push_s, pop_s, slot_valid_s;
  logic [p_sz-2:0]   fifo_rdata_s;
  logic [AW:0]       occupancy_s, occ_next_s;
  logic              in_ready_q, in_ready_d;
  logic [p_sz-1:0]   slot_q, slot_d;
  logic [p_sz-2:0]   rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]  rx_count_q, rx_count_d;

  pe_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (p_sz - 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({in_dest, in_payload}),
    .rdata (fifo_rdata_s),
    .count (occupancy_s)
  );

  // The slot reloads whenever it is empty or its packet was accepted; a resend pins it.
  always_comb begin
    slot_valid_s = slot_q[p_sz-1];
    push_s       = in_valid && in_ready_q;
    pop_s        = (!slot_valid_s || !resend) && (occupancy_s != '0);
    if (slot_valid_s && resend) begin
      slot_d = slot_q;
    end else if (occupancy_s != '0) begin
      slot_d = {1'b1, fifo_rdata_s};
    end else begin
      slot_d = '0;
    end
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occupancy_s + 1'b1;
      2'b01:   occ_next_s = occupancy_s - 1'b1;
      default: occ_next_s = occupancy_s;
    endcase
    // Registered so a same-cycle pop never opens the door, and low through reset.
    in_ready_d = (occ_next_s != (AW+1)'(DEPTH));
  end

  always_comb begin
    rx_valid_d = interface_pe[p_sz-1];
    rx_data_d  = rx_data_q;
    rx_count_d = rx_count_q;
    if (interface_pe[p_sz-1]) begin
      rx_data_d  = interface_pe[p_sz-2:0];
      rx_count_d = rx_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q <= 1'b0;
      slot_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_count_q <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      slot_q     <= slot_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_count_q <= rx_count_d;
    end
  end

`ifdef PE_TX_RESEND_STATS_EN
  logic [CNT_W-1:0] resend_count_q, resend_count_d;

  always_comb begin
    resend_count_d = resend_count_q;
    if (slot_valid_s && resend) begin
      resend_count_d = resend_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resend_count_q <= '0;
    end else begin
      resend_count_q <= resend_count_d;
    end
  end

  assign resend_count = resend_count_q;
`else
  assign resend_count = '0;
`endif

  assign in_ready     = in_ready_q;
  assign pe_interface = slot_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_count     = rx_count_q;
  assign occupancy    = occupancy_s;

endmodule

// File: tb/tb_pe_tx_queue.sv
// Scoreboard bench for pe_tx_queue: accepted words are queued as expected packets and
// checked against the output slot every cycle and when the network accepts them.
module tb_pe_tx_queue;
  import bft_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_dest;
  logic [26:0] in_payload;
  logic [31:0] pe_interface;
  logic [31:0] interface_pe;
  logic        resend;
  logic [30:0] rx_data;
  logic        rx_valid;
  logic [15:0] rx_count;
  logic [2:0]  occupancy;
  logic [15:0] resend_count;

  pe_tx_queue #(
    .num_leaves (16),
    .payload_sz (27),
    .p_sz       (32),
    .DEPTH      (DEPTH),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dest      (in_dest),
    .in_payload   (in_payload),
    .pe_interface (pe_interface),
    .interface_pe (interface_pe),
    .resend       (resend),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_count     (rx_count),
    .occupancy    (occupancy),
    .resend_count (resend_count)
  );

  always #5 clk = ~clk;

`ifdef PE_TX_RESEND_STATS_EN
  localparam logic [31:0] RS_AFTER_HOLD = 32'd3;
`else
  localparam logic [31:0] RS_AFTER_HOLD = 32'd0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [30:0] pend_q[$];

  bit          m_slot_v;
  int          m_count;
  bit          m_ready;
  logic [30:0] m_rx_data;
  bit          m_rx_v;
  logic [15:0] m_rx_cnt;
  logic [15:0] m_rs_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: checks handshake state, advances the model across the edge, checks outputs.
  task automatic step();
    bit          acc, rs, pop;
    logic [31:0] in_pkt, pe_prev, rxw;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("occupancy", {29'd0, occupancy}, m_count);
    acc     = in_valid && m_ready;
    rs      = resend;
    in_pkt  = make_pkt(in_dest, in_payload);
    rxw     = interface_pe;
    pe_prev = pe_interface;
    @(posedge clk);
    if (m_slot_v && !rs) begin
      if (exp_q.size() == 0) chk("tx_underflow", pe_prev, 32'd0);
      else chk("tx_accept", pe_prev, exp_q.pop_front());
    end
`ifdef PE_TX_RESEND_STATS_EN
    if (m_slot_v && rs) m_rs_cnt++;
`endif
    pop      = (!m_slot_v || !rs) && (m_count != 0);
    m_slot_v = (m_slot_v && rs) || pop;
    if (acc) m_count++;
    if (pop) m_count--;
    m_ready = (m_count != DEPTH);
    if (acc) exp_q.push_back(in_pkt);
    if (rxw[31]) begin
      m_rx_data = rxw[30:0];
      m_rx_v    = 1'b1;
      m_rx_cnt++;
    end else begin
      m_rx_v = 1'b0;
    end
    @(negedge clk);
    if (m_slot_v && exp_q.size() != 0) chk("tx_slot", pe_interface, exp_q[0]);
    else if (m_slot_v) chk("tx_slot_lost", 32'd0, 32'd1);
    else chk("tx_idle", pe_interface, 32'd0);
    chk("rx_valid", {31'd0, rx_valid}, {31'd0, m_rx_v});
    chk("rx_data", {1'b0, rx_data}, {1'b0, m_rx_data});
    chk("rx_count", {16'd0, rx_count}, {16'd0, m_rx_cnt});
    chk("resend_count", {16'd0, resend_count}, {16'd0, m_rs_cnt});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pe", pe_interface, 32'd0);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {1'b0, rx_data}, 32'd0);
    chk("rst_rx_count", {16'd0, rx_count}, 32'd0);
    chk("rst_rs_count", {16'd0, resend_count}, 32'd0);
    exp_q.delete();
    pend_q.delete();
    m_slot_v = 1'b0; m_count = 0; m_ready = 1'b0;
    m_rx_data = '0; m_rx_v = 1'b0; m_rx_cnt = '0; m_rs_cnt = '0;
    in_valid = 1'b0; resend = 1'b0; interface_pe = '0;
    in_dest = '0; in_payload = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Feeds pend_q with resend high for the first rs_hi cycles; bounded drain.
  task automatic run(input int rs_hi, input int max_cyc);
    bit acc_now;
    for (int c = 0; c < max_cyc; c++) begin
      resend   = (c < rs_hi);
      in_valid = (pend_q.size() != 0);
      if (in_valid) {in_dest, in_payload} = pend_q[0];
      acc_now = in_valid && m_ready;
      step();
      if (acc_now) void'(pend_q.pop_front());
      if (pend_q.size() == 0 && exp_q.size() == 0 && c >= rs_hi) break;
    end
    in_valid = 1'b0;
    resend   = 1'b0;
    chk("drain", pend_q.size() + exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    #2;
    do_reset();

    // Idle cycle: in_ready rises one edge after reset release.
    step();

    // Single packet latency.
    in_valid = 1'b1; in_dest = 4'd5; in_payload = 27'h0012345;
    step();
    in_valid = 1'b0;
    step();
    chk("lat_pkt", pe_interface, 32'hA8012345);
    step();
    chk("lat_clear", pe_interface, 32'd0);
    chk("lat_occ", {29'd0, occupancy}, 32'd0);

    // Same packet held by three resend cycles.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    resend = 1'b1;
    repeat (3) step();
    chk("hold_pkt", pe_interface, 32'hA8012345);
    resend = 1'b0;
    step();
    step();
    chk("hold_rs_cnt", {16'd0, resend_count}, RS_AFTER_HOLD);

    // RX capture then invalid word.
    interface_pe = 32'h80000007;
    step();
    chk("rx_pulse", {31'd0, rx_valid}, 32'd1);
    chk("rx_word", {1'b0, rx_data}, 32'h00000007);
    chk("rx_cnt1", {16'd0, rx_count}, 32'd1);
    interface_pe = 32'h00000009;
    step();
    chk("rx_ignore", {1'b0, rx_data}, 32'h00000007);
    interface_pe = 32'd0;

    // Six words against a held slot: FIFO fills, extras stall, then drain in order.
    for (int i = 0; i < 6; i++) pend_q.push_back({4'(i + 1), 27'(32'h100 + i)});
    run(12, 60);

    // Random traffic with random resend and RX noise.
    for (int c = 0; c < 200; c++) begin
      bit acc_now;
      if (pend_q.size() < 3 && $urandom_range(0, 1) == 1)
        pend_q.push_back(31'($urandom));
      in_valid = (pend_q.size() != 0) && ($urandom_range(0, 3) != 0);
      if (in_valid) {in_dest, in_payload} = pend_q[0];
      resend       = ($urandom_range(0, 2) == 0);
      interface_pe = $urandom;
      acc_now      = in_valid && m_ready;
      step();
      if (acc_now) void'(pend_q.pop_front());
    end
    interface_pe = 32'd0;
    run(0, 40);

    // Reset while entries are queued and resend is high.
    for (int i = 0; i < 4; i++) pend_q.push_back({4'(15 - i), 27'(32'h7000 + i)});
    for (int c = 0; c < 6; c++) begin
      bit acc_now;
      resend   = 1'b1;
      in_valid = (pend_q.size() != 0);
      if (in_valid) {in_dest, in_payload} = pend_q[0];
      acc_now = in_valid && m_ready;
      step();
      if (acc_now) void'(pend_q.pop_front());
    end
    chk("pre_rst_occ", {29'd0, occupancy}, 32'd3);
    do_reset();
    step();
    pend_q.push_back({4'd9, 27'h0ABCDEF});
    run(0, 10);
    chk("post_rst_idle", pe_interface, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
